// File: rtl/melody_player.sv
// ----------------------------------------------------------------------------
// melody_player
//   Autoplay source for the electronic keyboard. Walks a note list held in a
//   synchronous ROM and presents one key at a time on an 8-bit active-low
//   key vector, formatted exactly like the physical key bank so the tone
//   generator can be muxed between a human player and this block.
//
//   ROM word: [7:5] pitch, [4] rest, [3:0] duration in beats (0 = end mark).
//
// Ports
//   clk       in   1       system clock
//   rst_n     in   1       asynchronous active-low reset
//   start     in   1       pulse: begin playback at address 0 (ignored if busy)
//   stop      in   1       abort playback; wins over everything
//   loop      in   1       sampled at end of song: 1 = restart at address 0
//   rom_addr  out  ADDR_W  registered song ROM address
//   rom_data  in   8       ROM word, valid one cycle after rom_addr
//   key_out   out  8       active-low one-hot key vector, 8'hFF = no key
//   busy      out  1       high whenever not idle
//   done      out  1       one-cycle pulse when the song ends without looping
// ----------------------------------------------------------------------------
module melody_player #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        key_out,
    output logic              busy,
    output logic              done
);

    // One cycle counter serves both the beat timer and the gap timer.
    localparam int CNT_MAX = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        NOTE,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        key_q, key_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        beats_q, beats_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [2:0] word_pitch;
    logic       word_rest;
    logic [3:0] word_dur;

    assign word_pitch = rom_data[7:5];
    assign word_rest  = rom_data[4];
    assign word_dur   = rom_data[3:0];

    // Pitch 1..7 pulls bit p-1 low; pitch 0 maps to the top key (bit 7).
    function automatic logic [7:0] decode_pitch(input logic [2:0] p);
        logic [7:0] k;
        k = 8'hFF;
        if (p == 3'd0) begin
            k[7] = 1'b0;
        end else begin
            k[p - 3'd1] = 1'b0;
        end
        return k;
    endfunction

    // Next-state logic. The end-of-song rule (LOAD end mark, or GAP at the
    // last ROM address) loops only when the address is non-zero, so a song
    // whose first word is the end mark finishes instead of spinning.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        key_d   = key_q;
        beats_d = beats_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                key_d = 8'hFF;
                if (start) begin
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (word_dur == 4'd0) begin
                    if (loop && (addr_q != '0)) begin
                        addr_d  = '0;
                        state_d = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    key_d   = word_rest ? 8'hFF : decode_pitch(word_pitch);
                    beats_d = word_dur;
                    cnt_d   = '0;
                    state_d = NOTE;
                end
            end
            NOTE: begin
                if (cnt_q == CNT_W'(BEAT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    beats_d = beats_q - 4'd1;
                    if (beats_q == 4'd1) begin
                        key_d   = 8'hFF;
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                key_d = 8'hFF;
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (addr_q == {ADDR_W{1'b1}}) begin
                        if (loop) begin
                            addr_d  = '0;
                            state_d = FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                key_d   = 8'hFF;
            end
        endcase

        // stop overrides every transition above, including a same-cycle start.
        if (stop) begin
            state_d = IDLE;
            addr_d  = '0;
            key_d   = 8'hFF;
            beats_d = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // key_out clears asynchronously so a reset mid-note silences at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            key_q   <= 8'hFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            beats_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rom_addr = addr_q;
    assign key_out  = key_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_melody_player.sv
// ----------------------------------------------------------------------------
// tb_melody_player
//   Scoreboard bench for melody_player with BEAT_CYCLES=4, GAP_CYCLES=2,
//   ADDR_W=2. Stimulus pushes the expected key_out changes (value, length of
//   the previous run, rom_addr at that moment) and done pulses into a queue;
//   a negedge monitor pops and compares whenever the DUT changes key_out or
//   pulses done.
// ----------------------------------------------------------------------------
module tb_melody_player;

    localparam int BEAT = 4;
    localparam int GAPC = 2;
    localparam int AW   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data = 8'h00;
    logic [7:0]    key_out;
    logic          busy;
    logic          done;

    logic [7:0] rom [0:3];

    typedef struct {
        int         kind;   // 0 = key_out change, 1 = done pulse
        logic [7:0] val;
        int         run;    // cycles the previous key value lasted, -1 = skip
        int         addr;   // expected rom_addr, -1 = skip
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         last_change = 0;
    int         done_seen = 0;
    logic [7:0] last_key = 8'hFF;
    logic       mon_en = 1'b0;

    melody_player #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAPC),
        .ADDR_W     (AW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .key_out (key_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM: data follows the address by one cycle.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Monitor: compares each observed output event against the queue head.
    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        cyc = cyc + 1;
        if (mon_en) begin
            if (key_out !== last_key) begin
                n_cmp = n_cmp + 1;
                if (exp_q.size() == 0) begin
                    n_bad = n_bad + 1;
                    $display("[TB] FAIL key_event: unexpected key_out=%h (no event expected)", key_out);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (e.kind == 0) && (key_out === e.val) &&
                         (e.run < 0 || (cyc - last_change) == e.run) &&
                         (e.addr < 0 || int'(rom_addr) == e.addr);
                    if (!ok) begin
                        n_bad = n_bad + 1;
                        $display("[TB] FAIL key_event: got key=%h run=%0d addr=%0d, expected kind=%0d key=%h run=%0d addr=%0d",
                                 key_out, cyc - last_change, rom_addr, e.kind, e.val, e.run, e.addr);
                    end
                end
                last_change = cyc;
            end
            if (done === 1'b1) begin
                done_seen = done_seen + 1;
                n_cmp = n_cmp + 1;
                if (exp_q.size() == 0) begin
                    n_bad = n_bad + 1;
                    $display("[TB] FAIL done_event: unexpected done pulse, addr=%0d", rom_addr);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (e.kind == 1) && (e.addr < 0 || int'(rom_addr) == e.addr);
                    if (!ok) begin
                        n_bad = n_bad + 1;
                        $display("[TB] FAIL done_event: got done addr=%0d, expected kind=%0d key=%h addr=%0d",
                                 rom_addr, e.kind, e.val, e.addr);
                    end
                end
            end
        end
        last_key = key_out;
    end

    task automatic pushKey(input logic [7:0] v, input int run, input int addr);
        ev_t e;
        e.kind = 0; e.val = v; e.run = run; e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic pushDone(input int addr);
        ev_t e;
        e.kind = 1; e.val = 8'hFF; e.run = -1; e.addr = addr;
        exp_q.push_back(e);
    endtask

    // Drives start/stop for one cycle; returns 1 time unit after the edge
    // that sampled them.
    task automatic applyStimulus(input logic s_start, input logic s_stop);
        @(posedge clk);
        #1;
        start = s_start;
        stop  = s_stop;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp = n_cmp + 1;
        if (actual !== expected) begin
            n_bad = n_bad + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic waitDone(input string name, input int budget);
        int  seen0;
        bit  hit;
        seen0 = done_seen;
        hit   = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk);
            if (done_seen != seen0) hit = 1'b1;
        end
        n_cmp = n_cmp + 1;
        if (!hit) begin
            n_bad = n_bad + 1;
            $display("[TB] FAIL %s: done not seen within %0d cycles, expected a done pulse", name, budget);
        end
        #1;
    endtask

    task automatic checkQueue(input string name);
        n_cmp = n_cmp + 1;
        if (exp_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("[TB] FAIL %s: %0d expected events never observed, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic loadSong();
        rom[0] = 8'h62;   // pitch 3, dur 2 -> 8'hFB
        rom[1] = 8'h11;   // rest, dur 1
        rom[2] = 8'h01;   // pitch 0, dur 1 -> 8'h7F
        rom[3] = 8'h00;   // end mark
    endtask

    task automatic pushBasicSong();
        pushKey(8'hFB, -1, 0);
        pushKey(8'hFF,  8, 0);
        pushKey(8'h7F, 12, 2);
        pushKey(8'hFF,  4, 2);
        pushDone(3);
    endtask

    // Hard safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        loadSong();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] reset values");
        checkOutput("reset_key",  32'(key_out),  32'hFF);
        checkOutput("reset_busy", 32'(busy),     32'h0);
        checkOutput("reset_done", 32'(done),     32'h0);
        checkOutput("reset_addr", 32'(rom_addr), 32'h0);
        mon_en = 1'b1;

        $display("[TB] basic play");
        pushBasicSong();
        applyStimulus(1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput("latency_before", 32'(key_out), 32'hFF);
        @(posedge clk); #1;
        checkOutput("latency_first_key", 32'(key_out), 32'hFB);
        waitCycles(13);
        checkOutput("addr_during_rest", 32'(rom_addr), 32'h1);
        checkOutput("busy_during_rest", 32'(busy), 32'h1);
        waitDone("basic_done", 100);
        checkOutput("basic_busy_after", 32'(busy), 32'h0);
        checkOutput("basic_key_after", 32'(key_out), 32'hFF);
        waitCycles(5);
        checkQueue("basic_queue");

        $display("[TB] start while busy");
        pushBasicSong();
        applyStimulus(1'b1, 1'b0);
        waitCycles(3);
        applyStimulus(1'b1, 1'b0);
        waitDone("restart_done", 100);
        waitCycles(5);
        checkQueue("restart_queue");

        $display("[TB] loop");
        loop = 1'b1;
        pushKey(8'hFB, -1, 0);
        pushKey(8'hFF,  8, 0);
        pushKey(8'h7F, 12, 2);
        pushKey(8'hFF,  4, 2);
        pushKey(8'hFB,  6, 0);
        pushKey(8'hFF,  8, 0);
        applyStimulus(1'b1, 1'b0);
        waitCycles(44);
        applyStimulus(1'b0, 1'b1);
        loop = 1'b0;
        checkOutput("loop_stop_busy", 32'(busy), 32'h0);
        checkOutput("loop_stop_addr", 32'(rom_addr), 32'h0);
        waitCycles(5);
        checkQueue("loop_queue");

        $display("[TB] stop mid-note");
        pushKey(8'hFB, -1, 0);
        pushKey(8'hFF,  3, 0);
        applyStimulus(1'b1, 1'b0);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stop_key",  32'(key_out),  32'hFF);
        checkOutput("stop_busy", 32'(busy),     32'h0);
        checkOutput("stop_addr", 32'(rom_addr), 32'h0);
        waitCycles(40);
        checkQueue("stop_queue");

        $display("[TB] start with stop");
        applyStimulus(1'b1, 1'b1);
        checkOutput("startstop_busy", 32'(busy), 32'h0);
        waitCycles(10);
        checkOutput("startstop_busy_later", 32'(busy), 32'h0);
        checkQueue("startstop_queue");

        $display("[TB] empty song with loop");
        rom[0] = 8'h00;
        loop   = 1'b1;
        pushDone(0);
        applyStimulus(1'b1, 1'b0);
        waitDone("empty_done", 20);
        waitCycles(10);
        checkOutput("empty_busy", 32'(busy), 32'h0);
        checkQueue("empty_queue");
        loop = 1'b0;

        $display("[TB] full rom without end mark");
        rom[0] = 8'h21;   // pitch 1 -> FE
        rom[1] = 8'h41;   // pitch 2 -> FD
        rom[2] = 8'h81;   // pitch 4 -> F7
        rom[3] = 8'hA1;   // pitch 5 -> EF
        pushKey(8'hFE, -1, 0);
        pushKey(8'hFF,  4, 0);
        pushKey(8'hFD,  4, 1);
        pushKey(8'hFF,  4, 1);
        pushKey(8'hF7,  4, 2);
        pushKey(8'hFF,  4, 2);
        pushKey(8'hEF,  4, 3);
        pushKey(8'hFF,  4, 3);
        pushDone(3);
        applyStimulus(1'b1, 1'b0);
        waitDone("full_done", 100);
        checkOutput("full_busy", 32'(busy), 32'h0);
        checkOutput("full_no_wrap", 32'(rom_addr), 32'h3);
        waitCycles(10);
        checkQueue("full_queue");

        $display("[TB] reset mid-note");
        loadSong();
        pushKey(8'hFB, -1, 0);
        applyStimulus(1'b1, 1'b0);
        waitCycles(4);
        pushKey(8'hFF, -1, -1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_key",  32'(key_out), 32'hFF);
        checkOutput("async_reset_busy", 32'(busy),    32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        waitCycles(10);
        checkOutput("after_reset_busy", 32'(busy), 32'h0);
        checkQueue("reset_queue");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
